game_round_ctrl: RTL and testbench
==================================

// Module: game_round_ctrl
// PURPOSE
//  Top-level game sequencer for the whack-a-mole datapath. Owns game flow (idle, arm, play, show),
//  the game and round countdowns, and the difficulty level. Tells the pattern FSM when to latch a
//  new pattern, and owns score, high score, num_lit and the round preset.
//  Sits between the ui_in buttons, the pattern FSM (hit pulse) and the 7-seg/score drivers.
// PARAMETERS
//  GAME_TICKS  60000  play-phase length in clk cycles (1..65535)
//  ROUND_T0    5000   round length at level 0, cycles
//  ROUND_STEP  1000   round length reduction per level
//  ROUND_MIN   2000   floor on round length
//  LEVEL_HITS  5      hits needed to advance one level
//  MAX_LEVEL   3      highest level (level width 2 bits)
//  MAX_MISSES  3      expired rounds that end the game early
//  ARM_TICKS   1000   consecutive all-released cycles required before play
//  SHOW_TICKS  20000  score-display duration, cycles
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  start_btn    in   1  start button (ui_in[7]), level, synchronized
//  any_btn      in   1  OR of mole buttons ui_in[6:0]
//  hit          in   1  1-cycle pulse from pattern FSM: current pattern fully pressed
//  round_start  out  1  1-cycle pulse: pattern FSM latches new pattern, clears lockout
//  miss         out  1  1-cycle pulse: round expired without hit
//  play_active  out  1  high while in PLAY
//  show_score   out  1  high while in SHOW (7-seg shows score digit)
//  new_high     out  1  set on SHOW entry if score beat high_score; cleared on next ARM
//  state        out  2  IDLE=00 ARM=01 PLAY=10 SHOW=11
//  level        out  2  current difficulty level
//  num_lit      out  3  level+1, segments per pattern
//  score        out  8  hits this game, saturates at 255
//  high_score   out  8  best score since reset
// BEHAVIOUR
//  - Reset: state=IDLE. Every output 0 except num_lit=1. All counters and the start_btn edge register are 0.
//  - IDLE: rising edge of start_btn (registered previous value) -> ARM. On the transition, clear
//    score, level, hit-in-level count, miss count and new_high. Score holds its last value while in IDLE.
//  - ARM: release counter increments while start_btn==0 && any_btn==0. Any press resets it to 0.
//    On reaching ARM_TICKS -> PLAY.
//  - PLAY entry: game_cnt<=GAME_TICKS; round_start asserted in the first PLAY cycle.
//  - round_start cycle loads round_cnt<=preset(level); preset = max(ROUND_T0-level*ROUND_STEP, ROUND_MIN),
//    computed in 16-bit with no underflow (clamp before subtracting).
//    round_cnt decrements every later PLAY cycle. When it reaches 0 (exactly preset cycles after round_start):
//    miss pulse, miss count +1 (saturating), round_start on the next cycle.
//  - hit (honoured only in PLAY, not in the round_start cycle): score+1 sat 255, hit count+1.
//    If hit count reaches LEVEL_HITS: hit count<=0 and level+1 when level<MAX_LEVEL.
//    round_start follows on the next cycle and uses the new level's preset.
//  - hit and round expiry in the same cycle: hit wins, no miss.
//  - game_cnt decrements every PLAY cycle. PLAY -> SHOW when game_cnt reaches 0 or miss count
//    reaches MAX_MISSES. A hit in that same cycle is still scored. No round_start is issued after the transition.
//  - SHOW entry: if score>high_score then high_score<=score and new_high<=1. Show counter runs
//    SHOW_TICKS cycles -> IDLE. start_btn is ignored in SHOW.
//  - hit, any_btn and start_btn are ignored outside the states that use them.
//  - Asynchronous reset mid-game returns to IDLE immediately and clears high_score.
// TESTING (GAME_TICKS=200 ROUND_T0=20 ROUND_STEP=5 ROUND_MIN=10 LEVEL_HITS=2 MAX_MISSES=3 ARM_TICKS=4 SHOW_TICKS=8)
//  1 Reset, no stimulus -> state=00, all outputs 0, num_lit=1; start_btn held high -> one ARM entry only.
//  2 Start, hold any_btn 3 cycles, release -> PLAY exactly 4 cycles after release; round_start in first PLAY cycle.
//  3 Never hit -> miss pulses 20 cycles after each round_start; 3rd miss -> SHOW, score=0, new_high=0.
//  4 Hit 2 cycles after each round_start x6 -> score=6, level=3 (sat), num_lit=4, presets 20,15,10,10.
//  5 hit on the round_cnt==0 cycle -> score+1, no miss; hit in the final PLAY cycle -> counted, then SHOW.
//  6 Game1 score 6, game2 score 4 -> high_score stays 6, new_high=0 in game2; rst_n low mid-PLAY -> IDLE, high_score=0.

Source files
------------

// File: rtl/game_round_ctrl.sv
// Whack-a-mole game sequencer: runs idle/arm/play/show flow, game and round countdowns,
// difficulty level, score and high score, and tells the pattern FSM when to start a round.
module game_round_ctrl #(
    parameter int unsigned GAME_TICKS = 60000,
    parameter int unsigned ROUND_T0   = 5000,
    parameter int unsigned ROUND_STEP = 1000,
    parameter int unsigned ROUND_MIN  = 2000,
    parameter int unsigned LEVEL_HITS = 5,
    parameter int unsigned MAX_LEVEL  = 3,
    parameter int unsigned MAX_MISSES = 3,
    parameter int unsigned ARM_TICKS  = 1000,
    parameter int unsigned SHOW_TICKS = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       any_btn,
    input  logic       hit,
    output logic       round_start,
    output logic       miss,
    output logic       play_active,
    output logic       show_score,
    output logic       new_high,
    output logic [1:0] state,
    output logic [1:0] level,
    output logic [2:0] num_lit,
    output logic [7:0] score,
    output logic [7:0] high_score
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        PLAY = 2'b10,
        SHOW = 2'b11
    } state_t;

    localparam logic [15:0] GAME_T   = 16'(GAME_TICKS);
    localparam logic [15:0] ARM_T    = 16'(ARM_TICKS);
    localparam logic [15:0] SHOW_T   = 16'(SHOW_TICKS);
    localparam logic [15:0] RMIN     = 16'(ROUND_MIN);
    localparam logic [17:0] R0       = 18'(ROUND_T0);
    localparam logic [17:0] RSTEP    = 18'(ROUND_STEP);
    localparam logic [17:0] RSPAN    = (ROUND_T0 > ROUND_MIN) ? 18'(ROUND_T0 - ROUND_MIN) : 18'd0;
    localparam logic [7:0]  LVL_HITS = 8'(LEVEL_HITS);
    localparam logic [7:0]  MISS_MAX = 8'(MAX_MISSES);
    localparam logic [1:0]  LVL_MAX  = 2'(MAX_LEVEL);

    state_t      state_q, state_d;
    logic        start_prev_q, start_prev_d;
    logic        rs_q, rs_d;
    logic        new_high_q, new_high_d;
    logic [1:0]  level_q, level_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  high_q, high_d;
    logic [7:0]  hit_cnt_q, hit_cnt_d;
    logic [7:0]  miss_cnt_q, miss_cnt_d;
    logic [15:0] arm_cnt_q, arm_cnt_d;
    logic [15:0] game_cnt_q, game_cnt_d;
    logic [15:0] round_cnt_q, round_cnt_d;
    logic [15:0] show_cnt_q, show_cnt_d;

    logic [17:0] round_dec;
    logic [15:0] preset;
    logic        hit_ok;
    logic        round_expire;

    // Clamp against the floor before subtracting so high levels never wrap.
    always_comb begin
        round_dec = 18'(level_q) * RSTEP;
        if (round_dec >= RSPAN) begin
            preset = RMIN;
        end else begin
            preset = 16'(R0 - round_dec);
        end
    end

    assign hit_ok       = (state_q == PLAY) && hit && !rs_q;
    assign round_expire = (state_q == PLAY) && !rs_q && (round_cnt_q <= 16'd1);

    always_comb begin
        state_d      = state_q;
        start_prev_d = start_btn;
        rs_d         = 1'b0;
        new_high_d   = new_high_q;
        level_d      = level_q;
        score_d      = score_q;
        high_d       = high_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        arm_cnt_d    = arm_cnt_q;
        game_cnt_d   = game_cnt_q;
        round_cnt_d  = round_cnt_q;
        show_cnt_d   = show_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_btn && !start_prev_q) begin
                    state_d    = ARM;
                    score_d    = 8'd0;
                    level_d    = 2'd0;
                    hit_cnt_d  = 8'd0;
                    miss_cnt_d = 8'd0;
                    new_high_d = 1'b0;
                    arm_cnt_d  = 16'd0;
                end
            end
            ARM: begin
                if (start_btn || any_btn) begin
                    arm_cnt_d = 16'd0;
                end else if (arm_cnt_q + 16'd1 >= ARM_T) begin
                    state_d    = PLAY;
                    arm_cnt_d  = 16'd0;
                    game_cnt_d = GAME_T;
                    rs_d       = 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt_q + 16'd1;
                end
            end
            PLAY: begin
                game_cnt_d = (game_cnt_q != 16'd0) ? game_cnt_q - 16'd1 : 16'd0;
                if (rs_q) begin
                    round_cnt_d = preset;
                end else if (round_cnt_q != 16'd0) begin
                    round_cnt_d = round_cnt_q - 16'd1;
                end
                // A hit landing on the expiry cycle takes priority over the miss.
                if (hit_ok) begin
                    rs_d = 1'b1;
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    if (hit_cnt_q + 8'd1 >= LVL_HITS) begin
                        hit_cnt_d = 8'd0;
                        if (level_q < LVL_MAX) begin
                            level_d = level_q + 2'd1;
                        end
                    end else begin
                        hit_cnt_d = hit_cnt_q + 8'd1;
                    end
                end else if (round_expire) begin
                    rs_d = 1'b1;
                    if (miss_cnt_q != 8'hFF) begin
                        miss_cnt_d = miss_cnt_q + 8'd1;
                    end
                end
                if (game_cnt_q <= 16'd1 || miss_cnt_d >= MISS_MAX) begin
                    state_d    = SHOW;
                    rs_d       = 1'b0;
                    show_cnt_d = 16'd0;
                    if (score_d > high_q) begin
                        high_d     = score_d;
                        new_high_d = 1'b1;
                    end
                end
            end
            SHOW: begin
                if (show_cnt_q + 16'd1 >= SHOW_T) begin
                    state_d    = IDLE;
                    show_cnt_d = 16'd0;
                end else begin
                    show_cnt_d = show_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            rs_q         <= 1'b0;
            new_high_q   <= 1'b0;
            level_q      <= 2'd0;
            score_q      <= 8'd0;
            high_q       <= 8'd0;
            hit_cnt_q    <= 8'd0;
            miss_cnt_q   <= 8'd0;
            arm_cnt_q    <= 16'd0;
            game_cnt_q   <= 16'd0;
            round_cnt_q  <= 16'd0;
            show_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            rs_q         <= rs_d;
            new_high_q   <= new_high_d;
            level_q      <= level_d;
            score_q      <= score_d;
            high_q       <= high_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            arm_cnt_q    <= arm_cnt_d;
            game_cnt_q   <= game_cnt_d;
            round_cnt_q  <= round_cnt_d;
            show_cnt_q   <= show_cnt_d;
        end
    end

    assign round_start = rs_q;
    assign miss        = round_expire && !hit;
    assign play_active = (state_q == PLAY);
    assign show_score  = (state_q == SHOW);
    assign new_high    = new_high_q;
    assign state       = state_q;
    assign level       = level_q;
    assign num_lit     = {1'b0, level_q} + 3'd1;
    assign score       = score_q;
    assign high_score  = high_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed scoreboard bench for game_round_ctrl using the small test parameter set.
module tb_game_round_ctrl;

    localparam int GAME_TICKS = 200;
    localparam int ROUND_T0   = 20;
    localparam int ROUND_STEP = 5;
    localparam int ROUND_MIN  = 10;
    localparam int LEVEL_HITS = 2;
    localparam int MAX_LEVEL  = 3;
    localparam int MAX_MISSES = 3;
    localparam int ARM_TICKS  = 4;
    localparam int SHOW_TICKS = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_btn;
    logic       any_btn;
    logic       hit;
    logic       round_start;
    logic       miss;
    logic       play_active;
    logic       show_score;
    logic       new_high;
    logic [1:0] state;
    logic [1:0] level;
    logic [2:0] num_lit;
    logic [7:0] score;
    logic [7:0] high_score;

    always #5 clk = ~clk;

    game_round_ctrl #(
        .GAME_TICKS (GAME_TICKS),
        .ROUND_T0   (ROUND_T0),
        .ROUND_STEP (ROUND_STEP),
        .ROUND_MIN  (ROUND_MIN),
        .LEVEL_HITS (LEVEL_HITS),
        .MAX_LEVEL  (MAX_LEVEL),
        .MAX_MISSES (MAX_MISSES),
        .ARM_TICKS  (ARM_TICKS),
        .SHOW_TICKS (SHOW_TICKS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_btn   (start_btn),
        .any_btn     (any_btn),
        .hit         (hit),
        .round_start (round_start),
        .miss        (miss),
        .play_active (play_active),
        .show_score  (show_score),
        .new_high    (new_high),
        .state       (state),
        .level       (level),
        .num_lit     (num_lit),
        .score       (score),
        .high_score  (high_score)
    );

    typedef struct {
        string tag;
        int    expv;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   t_play       = 0;
    int   score_m      = 0;
    int   level_m      = 0;
    int   hits_m       = 0;

    task automatic pushExpect(input string tag, input int v);
        exp_t e;
        e.tag  = tag;
        e.expv = v;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input int observed);
        exp_t e;
        tests_run++;
        if (sb.size() == 0) begin
            e.tag  = "scoreboard_empty";
            e.expv = -1;
        end else begin
            e = sb.pop_front();
        end
        assert (observed === e.expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", e.tag, observed, e.expv);
        end
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        pushExpect(tag, expected);
        checkOutput(observed);
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic h);
        start_btn = s;
        any_btn   = a;
        hit       = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic waitPlay(input int expected);
        int n = 0;
        pushExpect("arm_to_play_cycles", expected);
        do begin
            tick();
            n++;
        end while (state != 2'b10 && n < 50);
        checkOutput(n);
        check("round_start_first_play", int'(round_start), 1);
        t_play  = cyc;
        score_m = 0;
        level_m = 0;
        hits_m  = 0;
    endtask

    task automatic startGame();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        check("arm_entry", int'(state), 1);
        check("new_high_cleared_on_arm", int'(new_high), 0);
        check("score_cleared_on_arm", int'(score), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitPlay(ARM_TICKS);
    endtask

    // Called on a round_start cycle; presses hit d cycles later and returns one cycle after.
    task automatic hitAt(input int d);
        int early = 0;
        for (int i = 0; i < d; i++) begin
            tick();
            if (i < d - 1 && miss) early++;
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        #1;
        check("no_early_miss", early, 0);
        check("hit_suppresses_miss", int'(miss), 0);
        check("hit_cycle_in_play", int'(play_active), 1);
        if (score_m < 255) score_m++;
        hits_m++;
        if (hits_m >= LEVEL_HITS) begin
            hits_m = 0;
            if (level_m < MAX_LEVEL) level_m++;
        end
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic expireRound(input int preset);
        int n = 0;
        pushExpect("round_length", preset);
        do begin
            tick();
            n++;
        end while (!miss && n < 60);
        checkOutput(n);
        tick();
    endtask

    task automatic waitIdle(input int expected);
        int n = 0;
        pushExpect("show_length", expected);
        do begin
            tick();
            n++;
        end while (state != 2'b00 && n < 50);
        checkOutput(n);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int remaining;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_outputs",
              int'({round_start, miss, play_active, show_score, new_high, state,
                    level, num_lit, score, high_score}), 32'h0001_0000);
        check("reset_num_lit", int'(num_lit), 1);
        check("reset_state", int'(state), 0);

        // Holding start high enters ARM once and the held press keeps ARM from completing.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        check("start_edge_to_arm", int'(state), 1);
        repeat (6) tick();
        check("held_start_stays_arm", int'(state), 1);

        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        check("any_btn_blocks_play", int'(play_active), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitPlay(ARM_TICKS);

        // Game A: never hit, three misses end the game.
        expireRound(20);
        check("round_start_after_miss1", int'(round_start), 1);
        expireRound(20);
        check("round_start_after_miss2", int'(round_start), 1);
        expireRound(20);
        check("third_miss_to_show", int'(state), 3);
        check("no_round_start_in_show", int'(round_start), 0);
        check("show_score_flag", int'(show_score), 1);
        check("game_a_score", int'(score), 0);
        check("game_a_new_high", int'(new_high), 0);
        check("game_a_high", int'(high_score), 0);
        waitIdle(SHOW_TICKS);

        // Game B: level climb with preset checks, then play out the full timer.
        startGame();
        hitAt(2);
        check("rs_after_hit1", int'(round_start), 1);
        hitAt(2);
        check("level_after_2_hits", int'(level), 1);
        check("num_lit_level1", int'(num_lit), 2);
        expireRound(15);
        check("rs_after_lvl1_miss", int'(round_start), 1);
        hitAt(2);
        hitAt(2);
        check("level_after_4_hits", int'(level), 2);
        expireRound(10);
        check("rs_after_lvl2_miss", int'(round_start), 1);
        hitAt(2);
        hitAt(2);
        check("score_after_6_hits", int'(score), 6);
        check("level_max", int'(level), 3);
        check("num_lit_max", int'(num_lit), 4);
        hitAt(10);
        check("expiry_hit_scored", int'(score), 7);
        check("rs_after_expiry_hit", int'(round_start), 1);
        hitAt(2);
        check("level_saturates", int'(level), 3);
        check("score_model_mid", int'(score), score_m);
        for (int k = 0; k < 40 && state == 2'b10; k++) begin
            remaining = (GAME_TICKS - 1) - (cyc - t_play);
            if (remaining <= 10) begin
                hitAt(remaining);
                break;
            end else if (remaining == 11) begin
                hitAt(5);
            end else begin
                hitAt(10);
            end
            check("rs_after_fill_hit", int'(round_start), 1);
        end
        check("final_hit_then_show", int'(state), 3);
        check("play_length", cyc - t_play, GAME_TICKS);
        check("no_rs_after_timeout", int'(round_start), 0);
        check("game_b_score", int'(score), 21);
        check("game_b_score_model", int'(score), score_m);
        check("game_b_new_high", int'(new_high), 1);
        check("game_b_high", int'(high_score), 21);
        waitIdle(SHOW_TICKS);

        // Game C: lower score must leave the high score untouched.
        startGame();
        for (int k = 0; k < 4; k++) begin
            hitAt(2);
            check("game_c_rs", int'(round_start), 1);
        end
        check("game_c_level", int'(level), 2);
        expireRound(10);
        expireRound(10);
        expireRound(10);
        check("game_c_show", int'(state), 3);
        check("game_c_score", int'(score), 4);
        check("game_c_new_high", int'(new_high), 0);
        check("game_c_high_kept", int'(high_score), 21);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitIdle(SHOW_TICKS);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        tick();
        check("start_in_show_ignored", int'(state), 0);
        check("hit_ignored_in_idle", int'(score), 4);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();

        // Game D: asynchronous reset in the middle of play.
        startGame();
        hitAt(2);
        check("game_d_score", int'(score), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", int'(state), 0);
        check("async_reset_high", int'(high_score), 0);
        check("async_reset_score", int'(score), 0);
        check("async_reset_play", int'(play_active), 0);
        check("async_reset_num_lit", int'(num_lit), 1);
        #2;
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", int'(state), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
